// File: rtl/mac_tx_scheduler_if.sv
// Stream link carrying 64-bit beats with byte keep, framing and backpressure.
interface mac_tx_scheduler_if;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/mac_tx_scheduler.sv
// Frame-level arbiter merging the ARP and IP transmit streams toward the MAC framer,
// favouring ARP for up to ARP_BURST_MAX consecutive frames while IP is waiting.
module mac_tx_scheduler #(
  parameter int unsigned ARP_BURST_MAX = 4
) (
  input  logic               tx_axis_aclk,
  input  logic               tx_axis_areset,
  mac_tx_scheduler_if.slave  arp_tx_axis,
  mac_tx_scheduler_if.slave  ip_tx_axis,
  mac_tx_scheduler_if.master frame_tx_axis,
  output logic [15:0]        protocol_type,
  output logic               busy,
  output logic [15:0]        arp_frame_cnt,
  output logic [15:0]        ip_frame_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_ARP  = 3'b010,
    ST_IP   = 3'b100
  } state_t;

  localparam logic [3:0]  BURST_MAX = 4'(ARP_BURST_MAX);
  localparam logic [15:0] ETH_ARP   = 16'h0806;
  localparam logic [15:0] ETH_IP    = 16'h0800;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [3:0]  burst_cnt_r;
  logic [15:0] protocol_type_r;
  logic [15:0] arp_frame_cnt_r;
  logic [15:0] ip_frame_cnt_r;
  logic        arp_done_s;
  logic        ip_done_s;

  // A completion beat is the handshaken tlast of the source currently granted.
  assign arp_done_s = (state_r == ST_ARP) & arp_tx_axis.tvalid & frame_tx_axis.tready & arp_tx_axis.tlast;
  assign ip_done_s  = (state_r == ST_IP)  & ip_tx_axis.tvalid  & frame_tx_axis.tready & ip_tx_axis.tlast;

  // State register.
  always_ff @(posedge tx_axis_aclk) begin
    if (!tx_axis_areset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: grant decisions are taken only from IDLE and held until completion.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (arp_tx_axis.tvalid && (!ip_tx_axis.tvalid || (burst_cnt_r < BURST_MAX))) begin
          state_nxt_s = ST_ARP;
        end else if (ip_tx_axis.tvalid && (!arp_tx_axis.tvalid || (burst_cnt_r == BURST_MAX))) begin
          state_nxt_s = ST_IP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ARP: begin
        if (arp_done_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ARP;
        end
      end
      ST_IP: begin
        if (ip_done_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_IP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output mux: the granted source is passed straight through, everything else is quiet.
  always_comb begin
    frame_tx_axis.tdata  = 64'd0;
    frame_tx_axis.tkeep  = 8'd0;
    frame_tx_axis.tvalid = 1'b0;
    frame_tx_axis.tlast  = 1'b0;
    arp_tx_axis.tready   = 1'b0;
    ip_tx_axis.tready    = 1'b0;
    busy                 = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_ARP: begin
        frame_tx_axis.tdata  = arp_tx_axis.tdata;
        frame_tx_axis.tkeep  = arp_tx_axis.tkeep;
        frame_tx_axis.tvalid = arp_tx_axis.tvalid;
        frame_tx_axis.tlast  = arp_tx_axis.tlast;
        arp_tx_axis.tready   = frame_tx_axis.tready;
        busy                 = 1'b1;
      end
      ST_IP: begin
        frame_tx_axis.tdata  = ip_tx_axis.tdata;
        frame_tx_axis.tkeep  = ip_tx_axis.tkeep;
        frame_tx_axis.tvalid = ip_tx_axis.tvalid;
        frame_tx_axis.tlast  = ip_tx_axis.tlast;
        ip_tx_axis.tready    = frame_tx_axis.tready;
        busy                 = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Bookkeeping: EtherType latch, burst fairness count and completed-frame counters.
  always_ff @(posedge tx_axis_aclk) begin
    if (!tx_axis_areset) begin
      burst_cnt_r     <= 4'd0;
      protocol_type_r <= ETH_IP;
      arp_frame_cnt_r <= 16'd0;
      ip_frame_cnt_r  <= 16'd0;
    end else begin
      if ((state_r == ST_IDLE) && (state_nxt_s == ST_ARP)) begin
        protocol_type_r <= ETH_ARP;
      end else if ((state_r == ST_IDLE) && (state_nxt_s == ST_IP)) begin
        protocol_type_r <= ETH_IP;
      end
      if (arp_done_s) begin
        arp_frame_cnt_r <= arp_frame_cnt_r + 16'd1;
        if (burst_cnt_r < BURST_MAX) begin
          burst_cnt_r <= burst_cnt_r + 4'd1;
        end
      end
      // Only an IP completion restores ARP's burst allowance.
      if (ip_done_s) begin
        ip_frame_cnt_r <= ip_frame_cnt_r + 16'd1;
        burst_cnt_r    <= 4'd0;
      end
    end
  end

  assign protocol_type = protocol_type_r;
  assign arp_frame_cnt = arp_frame_cnt_r;
  assign ip_frame_cnt  = ip_frame_cnt_r;

endmodule

// File: tb/tb_mac_tx_scheduler.sv
// Randomised bench for mac_tx_scheduler: frame-level source generators, a behavioural
// arbitration model, per-cycle output comparison and a few directed scenarios.
module tb_mac_tx_scheduler;

  localparam int         BMAX    = 4;
  localparam logic [7:0] TAG_ARP = 8'hA5;
  localparam logic [7:0] TAG_IP  = 8'hC3;

  logic        clk;
  logic        rst_n;
  logic [15:0] protocol_type;
  logic        busy;
  logic [15:0] arp_cnt;
  logic [15:0] ip_cnt;

  mac_tx_scheduler_if arp_if ();
  mac_tx_scheduler_if ip_if ();
  mac_tx_scheduler_if fr_if ();

  mac_tx_scheduler #(.ARP_BURST_MAX(BMAX)) dut (
    .tx_axis_aclk   (clk),
    .tx_axis_areset (rst_n),
    .arp_tx_axis    (arp_if),
    .ip_tx_axis     (ip_if),
    .frame_tx_axis  (fr_if),
    .protocol_type  (protocol_type),
    .busy           (busy),
    .arp_frame_cnt  (arp_cnt),
    .ip_frame_cnt   (ip_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // model: granted source (0 none, 1 ARP, 2 IP), burst allowance, latched type, counters
  int          mst;
  int          mb;
  logic [15:0] mp, ma, mi;

  // source generators: frames left (-1 endless), current beat/length, length policy
  int          a_left, i_left, a_beat, i_beat, a_len, i_len, a_fix, i_fix;
  int          a_vpct, i_vpct, rdy_pct;
  logic [15:0] a_fno, i_fno;
  logic        rst_val;
  int          fwd_cnt;
  logic [7:0]  glog[$];
  logic [7:0]  exp_seq [10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick_len(input int fix);
    return (fix == 0) ? int'($urandom_range(1, 4)) : fix;
  endfunction

  task automatic drive_src();
    arp_if.tvalid = (a_left != 0) && (int'($urandom_range(0, 99)) < a_vpct);
    arp_if.tlast  = (a_beat == a_len - 1);
    arp_if.tdata  = {TAG_ARP, 8'h00, a_fno, 16'(a_beat), 16'(a_len)};
    arp_if.tkeep  = arp_if.tlast ? 8'h0F : 8'hFF;
    ip_if.tvalid  = (i_left != 0) && (int'($urandom_range(0, 99)) < i_vpct);
    ip_if.tlast   = (i_beat == i_len - 1);
    ip_if.tdata   = {TAG_IP, 8'h00, i_fno, 16'(i_beat), 16'(i_len)};
    ip_if.tkeep   = ip_if.tlast ? 8'h3F : 8'hFF;
    fr_if.tready  = int'($urandom_range(0, 99)) < rdy_pct;
    rst_n         = rst_val;
  endtask

  task automatic model_step();
    logic av, al, iv, il, fr, ahs, ihs;
    av = arp_if.tvalid; al = arp_if.tlast;
    iv = ip_if.tvalid;  il = ip_if.tlast;
    fr = fr_if.tready;
    if (!rst_n) begin
      mst = 0; mb = 0; mp = 16'h0800; ma = 16'd0; mi = 16'd0;
      a_beat = 0; i_beat = 0;
    end else begin
      ahs = (mst == 1) && av && fr;
      ihs = (mst == 2) && iv && fr;
      if (mst == 0) begin
        if (av && (!iv || mb < BMAX)) begin
          mst = 1; mp = 16'h0806;
        end else if (iv && (!av || mb == BMAX)) begin
          mst = 2; mp = 16'h0800;
        end
      end else if (ahs && al) begin
        mst = 0; ma = ma + 16'd1; mb = (mb < BMAX) ? mb + 1 : BMAX;
      end else if (ihs && il) begin
        mst = 0; mi = mi + 16'd1; mb = 0;
      end
      if (ahs) begin
        if (al) begin
          a_beat = 0; a_fno = a_fno + 16'd1; a_len = pick_len(a_fix);
          if (a_left > 0) a_left--;
        end else a_beat++;
      end
      if (ihs) begin
        if (il) begin
          i_beat = 0; i_fno = i_fno + 16'd1; i_len = pick_len(i_fix);
          if (i_left > 0) i_left--;
        end else i_beat++;
      end
    end
  endtask

  task automatic compare();
    logic [63:0] ed;
    logic [7:0]  ek;
    logic        ev, el, ear, eir;
    ed = 64'd0; ek = 8'd0; ev = 1'b0; el = 1'b0; ear = 1'b0; eir = 1'b0;
    if (mst == 1) begin
      ed = arp_if.tdata; ek = arp_if.tkeep; ev = arp_if.tvalid; el = arp_if.tlast; ear = fr_if.tready;
    end else if (mst == 2) begin
      ed = ip_if.tdata; ek = ip_if.tkeep; ev = ip_if.tvalid; el = ip_if.tlast; eir = fr_if.tready;
    end
    check("frame_beat", {fr_if.tdata, fr_if.tkeep, fr_if.tvalid, fr_if.tlast}, {ed, ek, ev, el});
    check("arp_tready", arp_if.tready, ear);
    check("ip_tready", ip_if.tready, eir);
    check("busy", busy, mst != 0);
    check("protocol_type", protocol_type, mp);
    check("arp_frame_cnt", arp_cnt, ma);
    check("ip_frame_cnt", ip_cnt, mi);
    if (fr_if.tvalid && fr_if.tready) begin
      fwd_cnt++;
      if (fr_if.tdata[31:16] == 16'd0) glog.push_back(fr_if.tdata[63:56]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    drive_src();
    @(negedge clk);
    compare();
  endtask

  task automatic drain();
    int k;
    if (a_left != 0) a_left = 1;
    if (i_left != 0) i_left = 1;
    a_vpct = 100; i_vpct = 100; rdy_pct = 100; rst_val = 1'b1;
    k = 0;
    while ((a_left != 0 || i_left != 0 || mst != 0) && k < 200) begin
      cycle();
      k++;
    end
    if (k >= 200) check("drain_timeout", 1'b1, 1'b0);
  endtask

  initial begin
    int   k;
    logic [15:0] c0;
    mst = 0; mb = 0; mp = 16'h0800; ma = 16'd0; mi = 16'd0;
    a_left = 0; i_left = 0; a_beat = 0; i_beat = 0; a_len = 1; i_len = 1;
    a_fix = 1; i_fix = 1; a_vpct = 100; i_vpct = 100; rdy_pct = 100;
    a_fno = 16'd0; i_fno = 16'd0; rst_val = 1'b0; fwd_cnt = 0;
    exp_seq = '{TAG_ARP, TAG_ARP, TAG_ARP, TAG_ARP, TAG_IP,
                TAG_ARP, TAG_ARP, TAG_ARP, TAG_ARP, TAG_IP};
    drive_src();

    // reset values
    repeat (3) cycle();
    check("rst_protocol_type", protocol_type, 16'h0800);
    check("rst_busy", busy, 1'b0);
    check("rst_counters", {arp_cnt, ip_cnt}, 32'd0);
    check("rst_frame_tvalid", fr_if.tvalid, 1'b0);
    rst_val = 1'b1;
    cycle();

    // lone 3-beat IP frame
    i_left = 1; i_len = 3; i_fix = 3; i_beat = 0; fwd_cnt = 0;
    cycle();
    cycle();
    check("ip3_grant_latency", busy, 1'b1);
    repeat (3) cycle();
    check("ip3_beats", fwd_cnt, 3);
    check("ip3_ip_cnt", ip_cnt, 16'd1);
    check("ip3_busy_low", busy, 1'b0);
    check("ip3_protocol_type", protocol_type, 16'h0800);

    // both sources always valid, single-beat frames: burst fairness order
    glog.delete();
    a_left = -1; i_left = -1; a_fix = 1; i_fix = 1; a_len = 1; i_len = 1; a_beat = 0; i_beat = 0;
    repeat (21) cycle();
    for (int j = 0; j < 10; j++)
      check("arp_ip_order", (j < glog.size()) ? glog[j] : 8'h00, exp_seq[j]);
    drain();

    // ARP raised while an IP frame with gaps and backpressure is in flight
    glog.delete();
    i_left = 1; i_len = 6; i_fix = 6; i_beat = 0; i_vpct = 60; rdy_pct = 50;
    k = 0;
    while (mst != 2 && k < 30) begin cycle(); k++; end
    if (k >= 30) check("ip6_grant_timeout", 1'b1, 1'b0);
    a_left = 1; a_len = 1; a_fix = 1; a_beat = 0; a_vpct = 100;
    k = 0;
    while (i_left != 0 && k < 300) begin cycle(); k++; end
    if (k >= 300) check("ip6_done_timeout", 1'b1, 1'b0);
    drain();
    check("no_preempt_count", glog.size(), 2);
    check("no_preempt_first", (glog.size() > 0) ? glog[0] : 8'h00, TAG_IP);
    check("no_preempt_second", (glog.size() > 1) ? glog[1] : 8'h00, TAG_ARP);

    // tlast held with tready low for 5 cycles
    c0 = mi;
    i_left = 1; i_len = 2; i_fix = 2; i_beat = 0; i_vpct = 100; rdy_pct = 100;
    cycle();
    cycle();
    rdy_pct = 0;
    cycle();
    repeat (5) begin
      cycle();
      check("tlast_hold_busy", busy, 1'b1);
      check("tlast_hold_cnt", ip_cnt, c0);
    end
    rdy_pct = 100;
    cycle();
    cycle();
    check("tlast_release_cnt", ip_cnt, c0 + 16'd1);
    check("tlast_release_busy", busy, 1'b0);
    repeat (2) cycle();
    check("tlast_counted_once", ip_cnt, c0 + 16'd1);

    // reset in the middle of a 4-beat ARP frame
    a_left = 1; a_len = 4; a_fix = 4; a_beat = 0; a_vpct = 100;
    cycle();
    cycle();
    cycle();
    rst_val = 1'b0;
    cycle();
    cycle();
    check("midrst_frame_tvalid", fr_if.tvalid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_arp_tready", arp_if.tready, 1'b0);
    check("midrst_counters", {arp_cnt, ip_cnt}, 32'd0);
    check("midrst_protocol_type", protocol_type, 16'h0800);
    rst_val = 1'b1;
    drain();

    // IP counter wrap from 16'hFFFF
    force dut.ip_frame_cnt_r = 16'hFFFF;
    mi = 16'hFFFF;
    #1;
    release dut.ip_frame_cnt_r;
    i_left = 1; i_len = 1; i_fix = 1; i_beat = 0;
    drain();
    check("ip_cnt_wrap", ip_cnt, 16'd0);

    // random traffic with gaps, backpressure and occasional resets
    a_fix = 0; i_fix = 0; a_left = -1; i_left = -1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        a_vpct  = int'($urandom_range(20, 100));
        i_vpct  = int'($urandom_range(20, 100));
        rdy_pct = int'($urandom_range(20, 100));
      end
      rst_val = ($urandom_range(0, 399) != 0);
      cycle();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mac_tx_scheduler.md
MAC_TX_SCHEDULER -- requirements
Module: mac_tx_scheduler

Interface
REQ-001 Parameter ARP_BURST_MAX, default 4: maximum consecutive ARP frames granted while IP is waiting; legal range 1..15.
REQ-002 tx_axis_aclk  in  1  single clock; all logic on rising edge.
REQ-003 tx_axis_areset  in  1  reset; synchronous, active-low.
REQ-004 arp_tx_axis_tdata/tkeep/tvalid/tlast  in  64/8/1/1  ARP source stream.
REQ-005 arp_tx_axis_tready  out  1  ARP source ready.
REQ-006 ip_tx_axis_tdata/tkeep/tvalid/tlast  in  64/8/1/1  IP source stream.
REQ-007 ip_tx_axis_tready  out  1  IP source ready.
REQ-008 frame_tx_axis_tdata/tkeep/tvalid/tlast  out  64/8/1/1  merged stream to MAC framer.
REQ-009 frame_tx_axis_tready  in  1  framer ready.
REQ-010 protocol_type  out  16  EtherType of the granted frame: 16'h0806 ARP, 16'h0800 IP.
REQ-011 busy  out  1  high while a frame is granted (state ARP or IP).
REQ-012 arp_frame_cnt, ip_frame_cnt  out  16 each  completed-frame counters.

Function
REQ-013 FSM states: IDLE, ARP, IP; encoded one-hot; state register updates only on tx_axis_aclk.
REQ-014 Request = source tvalid high; no separate not-empty inputs.
REQ-015 IDLE->ARP: arp tvalid=1 and (ip tvalid=0 or burst_cnt<ARP_BURST_MAX).
REQ-016 IDLE->IP: ip tvalid=1 and (arp tvalid=0 or burst_cnt==ARP_BURST_MAX).
REQ-017 IDLE with both tvalid=0: stay IDLE.
REQ-018 ARP/IP -> IDLE on the completion beat of the granted source: tvalid & tready & tlast, all high in the same cycle; otherwise hold state.
REQ-019 At least one IDLE cycle separates consecutive grants; grant decision latency = 1 cycle from request to first forwarded beat.
REQ-020 In ARP/IP: frame_tx_axis_* = granted source's tdata/tkeep/tvalid/tlast combinationally; granted tready = frame_tx_axis_tready; other source tready=0.
REQ-021 In IDLE: frame_tx_axis_tdata=0, tkeep=0, tvalid=0, tlast=0; both source treadys=0.
REQ-022 Grant is never preempted mid-frame; a tvalid gap of any length inside a frame keeps the grant.
REQ-023 burst_cnt (4-bit): +1 on ARP completion, saturates at ARP_BURST_MAX; cleared to 0 on IP completion; cleared when entering IDLE with ip tvalid=0 and state was ARP is NOT done (only IP completion clears).
REQ-024 protocol_type registered: loads 16'h0806 on IDLE->ARP, 16'h0800 on IDLE->IP; holds last value otherwise (including IDLE).
REQ-025 arp_frame_cnt/ip_frame_cnt +1 on their respective completion beat; wrap 16'hFFFF->0.
REQ-026 busy = (state != IDLE), combinational from state register.
REQ-027 Single-beat frame (tvalid & tlast on first granted beat with tready=1): completes in one cycle, returns to IDLE next cycle.
REQ-028 Source tvalid dropping while in IDLE before grant: no grant taken if tvalid=0 at the decision edge.

Reset
REQ-029 While tx_axis_areset=0 at a clock edge: state=IDLE, burst_cnt=0, protocol_type=16'h0800, arp_frame_cnt=0, ip_frame_cnt=0.
REQ-030 Reset asserted mid-frame: grant dropped at that edge; outputs follow REQ-021 next cycle; no counter update for the truncated frame.
REQ-031 After reset release, first grant evaluated on the first edge with tx_axis_areset=1.

Verification
REQ-032 Only IP sends 3-beat frame, tready=1 -> grant after 1 cycle, 3 beats forwarded, protocol_type=0x0800, ip_frame_cnt=1, busy low after beat 3.
REQ-033 ARP and IP both continuously valid, ARP_BURST_MAX=4, single-beat ARP -> grant order ARP,ARP,ARP,ARP,IP,ARP...; burst_cnt returns to 0 after IP.
REQ-034 Granted IP frame, tready toggled 1/0 and tvalid gaps, ARP raised mid-frame -> no ARP beat until IP tlast handshake; ARP granted next IDLE decision.
REQ-035 tlast with tready=0 held 5 cycles -> state stays IP; completion counted exactly once when tready=1.
REQ-036 Reset pulsed during beat 2 of a 4-beat ARP frame -> outputs zero, counters zero, protocol_type=0x0800.
REQ-037 ip_frame_cnt preloaded by 65535 frames (or forced) then one more -> wraps to 0.
